// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word reads to the ROM, buffers returned words
// in a small prefetch FIFO and presents {instr, pc} to decode over valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0800_0000,
    parameter logic [31:0] ROM_BASE     = 32'h0800_0000,
    parameter logic [31:0] ROM_SIZE     = 32'h0010_0000,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] rom_address,
    output logic        rom_write_enable,
    output logic [31:0] rom_data_in,
    input  logic [31:0] rom_data_out,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_fault
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic {S_FETCH, S_FAULT} state_t;
    state_t state, state_nxt;

    logic [31:0]      fetch_pc, in_flight_pc;
    logic             in_flight;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    logic [31:0]      fifo_instr [FIFO_DEPTH];
    logic [31:0]      fifo_pc    [FIFO_DEPTH];

    logic             pc_legal, issue, push, pop;
    logic [CW-1:0]    credit_used;

    assign rom_address      = fetch_pc;
    assign rom_write_enable = 1'b0;
    assign rom_data_in      = 32'h0;

    // Subtraction form avoids overflow of ROM_BASE + ROM_SIZE near the top of the map.
    assign pc_legal = (fetch_pc[1:0] == 2'b00) && (fetch_pc >= ROM_BASE) &&
                      ((fetch_pc - ROM_BASE) < ROM_SIZE);

    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready;
    assign push        = in_flight & ~branch_valid;
    assign instr       = instr_valid ? fifo_instr[rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]    : 32'h0;
    assign fetch_fault = (state == S_FAULT);

    // A slot freed by this cycle's pop is creditable now: its refill lands two
    // edges later, so streaming at one word per cycle cannot overflow.
    assign credit_used = CW'(count) + CW'(in_flight) - CW'(pop);
    assign issue = (state == S_FETCH) && !branch_valid && pc_legal &&
                   (credit_used < DEPTH_C);

    always_comb begin
        state_nxt = state;
        if (branch_valid)
            state_nxt = S_FETCH;
        else if (state == S_FETCH && !pc_legal)
            state_nxt = S_FAULT;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_FETCH;
            fetch_pc     <= RESET_VECTOR;
            in_flight_pc <= 32'h0;
            in_flight    <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_flight <= issue;
            if (branch_valid) begin
                fetch_pc <= branch_target;
            end else if (issue) begin
                fetch_pc     <= fetch_pc + 32'd4;
                in_flight_pc <= fetch_pc;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (branch_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: outputs are gated by instr_valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_instr[wr_ptr] <= rom_data_out;
            fifo_pc[wr_ptr]    <= in_flight_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a one-cycle-latency ROM model.
module tb_fetch_unit;
    logic        clock, reset_n;
    logic [31:0] rom_address, rom_data_in, rom_data_out;
    logic        rom_write_enable;
    logic        branch_valid, instr_valid, instr_ready, fetch_fault;
    logic [31:0] branch_target, instr, instr_pc;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit dut (
        .clock(clock), .reset_n(reset_n),
        .rom_address(rom_address), .rom_write_enable(rom_write_enable),
        .rom_data_in(rom_data_in), .rom_data_out(rom_data_out),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .fetch_fault(fetch_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h0800_0000) return 32'h0123_4567;
        if (a == 32'h0800_0004) return 32'h89AB_CDEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    always @(posedge clock) rom_data_out <= rom_word(rom_address);

    typedef struct {
        logic        ready;
        logic        bv;
        logic [31:0] tgt;
        logic        ev;
        logic [31:0] epc;
        logic        ef;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, input logic b, input logic [31:0] t,
                                input logic v, input logic [31:0] p, input logic f,
                                input logic [31:0] a);
        vec_t x;
        x.ready = r; x.bv = b; x.tgt = t; x.ev = v; x.epc = p; x.ef = f; x.eaddr = a;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle's inputs just after a negedge, check that cycle's outputs,
    // then advance to the next negedge.
    task automatic apply(input vec_t x, input string tag);
        instr_ready   = x.ready;
        branch_valid  = x.bv;
        branch_target = x.tgt;
        #1;
        check({tag, " valid"}, {31'h0, instr_valid}, {31'h0, x.ev});
        check({tag, " pc"},    instr_pc, x.ev ? x.epc : 32'h0);
        check({tag, " instr"}, instr, x.ev ? rom_word(x.epc) : 32'h0);
        check({tag, " fault"}, {31'h0, fetch_fault}, {31'h0, x.ef});
        check({tag, " addr"},  rom_address, x.eaddr);
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        // reset / stream start: valid two cycles after release, one word per cycle
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0800_0000));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0800_0004));
        vq.push_back(mk(1, 0, 0, 1, 32'h0800_0000, 0, 32'h0800_0008));
        vq.push_back(mk(1, 0, 0, 1, 32'h0800_0004, 0, 32'h0800_000C));
        vq.push_back(mk(1, 0, 0, 1, 32'h0800_0008, 0, 32'h0800_0010));
        // stall six cycles: head held, fetch address frozen
        for (int i = 0; i < 6; i++)
            vq.push_back(mk(0, 0, 0, 1, 32'h0800_000C, 0, 32'h0800_0014));
        vq.push_back(mk(1, 0, 0, 1, 32'h0800_000C, 0, 32'h0800_0014));
        vq.push_back(mk(1, 0, 0, 1, 32'h0800_0010, 0, 32'h0800_0018));
        vq.push_back(mk(1, 0, 0, 1, 32'h0800_0014, 0, 32'h0800_001C));
        // refill to full, then branch near the top of ROM
        vq.push_back(mk(0, 0, 0, 1, 32'h0800_0018, 0, 32'h0800_0020));
        vq.push_back(mk(0, 1, 32'h080F_FFF8, 1, 32'h0800_0018, 0, 32'h0800_0020));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 32'h080F_FFF8));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 32'h080F_FFFC));
        vq.push_back(mk(1, 0, 0, 1, 32'h080F_FFF8, 0, 32'h0810_0000));
        vq.push_back(mk(1, 0, 0, 1, 32'h080F_FFFC, 1, 32'h0810_0000));
        vq.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0810_0000));
        vq.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0810_0000));
        // unaligned and out-of-range targets fault, then a legal branch recovers
        vq.push_back(mk(1, 1, 32'h0800_0002, 0, 0, 1, 32'h0810_0000));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0800_0002));
        vq.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0800_0002));
        vq.push_back(mk(1, 1, 32'h0810_0000, 0, 0, 1, 32'h0800_0002));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0810_0000));
        vq.push_back(mk(1, 1, 32'h0800_0000, 0, 0, 1, 32'h0810_0000));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0800_0000));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0800_0004));
        vq.push_back(mk(1, 0, 0, 1, 32'h0800_0000, 0, 32'h0800_0008));
        vq.push_back(mk(1, 0, 0, 1, 32'h0800_0004, 0, 32'h0800_000C));
        // branch while a response returns and the head pops: 0x0800000C is dropped
        vq.push_back(mk(1, 1, 32'h0800_0100, 1, 32'h0800_0008, 0, 32'h0800_0010));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0800_0100));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0800_0104));
        vq.push_back(mk(1, 0, 0, 1, 32'h0800_0100, 0, 32'h0800_0108));
        vq.push_back(mk(1, 0, 0, 1, 32'h0800_0104, 0, 32'h0800_010C));

        // reset state, with a branch held during reset that must be ignored
        reset_n       = 1'b0;
        instr_ready   = 1'b1;
        branch_valid  = 1'b1;
        branch_target = 32'h0800_0040;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst valid", {31'h0, instr_valid}, 32'h0);
        check("rst instr", instr, 32'h0);
        check("rst pc",    instr_pc, 32'h0);
        check("rst fault", {31'h0, fetch_fault}, 32'h0);
        check("rst addr",  rom_address, 32'h0800_0000);
        check("rst we",    {31'h0, rom_write_enable}, 32'h0);
        check("rst din",   rom_data_in, 32'h0);
        branch_valid = 1'b0;
        reset_n      = 1'b1;

        foreach (vq[i]) apply(vq[i], $sformatf("v%0d", i));

        // asynchronous reset between edges while entries and a request are live
        #2;
        reset_n = 1'b0;
        #1;
        check("async valid", {31'h0, instr_valid}, 32'h0);
        check("async instr", instr, 32'h0);
        check("async pc",    instr_pc, 32'h0);
        check("async fault", {31'h0, fetch_fault}, 32'h0);
        check("async addr",  rom_address, 32'h0800_0000);
        @(negedge clock);
        reset_n = 1'b1;
        apply(mk(1, 0, 0, 0, 0, 0, 32'h0800_0000), "rr0");
        apply(mk(1, 0, 0, 0, 0, 0, 32'h0800_0004), "rr1");
        apply(mk(1, 0, 0, 1, 32'h0800_0000, 0, 32'h0800_0008), "rr2");
        apply(mk(1, 0, 0, 1, 32'h0800_0004, 0, 32'h0800_000C), "rr3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
